// File: rtl/mips_cpu_pkg.sv
// Shared PC-unit types and constants for mips_cpu_harvard.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DELAY  = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] DEFAULT_HALT_ADDR    = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES          = 32'd4;

endpackage

// File: rtl/mips_cpu_pc_unit.sv
// Program counter with one-slot branch delay sequencing and halt-on-fetch-of-HALT_ADDR.
// Optional MIPS_PC_ALIGN_CHECK_EN: misaligned redirect raises a sticky fault and halts.
module mips_cpu_pc_unit
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = DEFAULT_HALT_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] instr_address,
  output logic [31:0] pc_plus8,
  output logic        in_delay_slot,
  output logic        active,
  output logic        misalign_fault
);

  pc_state_t   r_state;
  pc_state_t   w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] r_target;
  logic [31:0] w_target_next;
  logic        r_active;
  logic        w_active_next;
  logic        w_advance;

`ifdef MIPS_PC_ALIGN_CHECK_EN
  logic        r_fault;
  logic        w_fault_next;
`endif

  assign w_advance = clk_enable & ~stall & (r_state != HALTED);

  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_target_next = r_target;
    w_active_next = r_active;
`ifdef MIPS_PC_ALIGN_CHECK_EN
    w_fault_next  = r_fault;
`endif
    if (w_advance) begin
      case (r_state)
        RUN: begin
          w_pc_next = r_pc + INSTR_BYTES;
          if (redirect_valid) begin
            w_target_next = redirect_target;
            w_state_next  = DELAY;
`ifdef MIPS_PC_ALIGN_CHECK_EN
            if (redirect_target[1:0] != 2'b00) begin
              w_fault_next = 1'b1;
            end
`endif
          end
        end
        DELAY: begin
          // Redirects seen while fetching the delay slot are dropped: first one wins.
`ifdef MIPS_PC_ALIGN_CHECK_EN
          if (r_fault) begin
            w_state_next  = HALTED;
            w_active_next = 1'b0;
          end else begin
            w_pc_next    = r_target;
            w_state_next = RUN;
          end
`else
          w_pc_next    = r_target;
          w_state_next = RUN;
`endif
        end
        default: ;
      endcase
      // Fetching HALT_ADDR stops the CPU on the same edge (JR r0, pc wrap).
      if (w_pc_next == HALT_ADDR) begin
        w_state_next  = HALTED;
        w_active_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= RUN;
      r_pc     <= RESET_VECTOR;
      r_target <= 32'h0;
      r_active <= 1'b1;
    end else begin
      r_state  <= w_state_next;
      r_pc     <= w_pc_next;
      r_target <= w_target_next;
      r_active <= w_active_next;
    end
  end

`ifdef MIPS_PC_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fault <= 1'b0;
    end else begin
      r_fault <= w_fault_next;
    end
  end

  assign misalign_fault = r_fault;
`else
  assign misalign_fault = 1'b0;
`endif

  assign instr_address = r_pc;
  assign pc_plus8      = r_pc + (INSTR_BYTES << 1);
  assign in_delay_slot = (r_state == DELAY);
  assign active        = r_active;

endmodule

// File: tb/tb_mips_cpu_pc_unit.sv
// Directed vector bench for mips_cpu_pc_unit; each row is one clock edge then a check.
module tb_mips_cpu_pc_unit;

`ifdef MIPS_PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enable = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic [31:0] instr_address;
  logic [31:0] pc_plus8;
  logic        in_delay_slot;
  logic        active;
  logic        misalign_fault;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mips_cpu_pc_unit dut (
    .clk            (clk),
    .reset          (reset),
    .clk_enable     (clk_enable),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .instr_address  (instr_address),
    .pc_plus8       (pc_plus8),
    .in_delay_slot  (in_delay_slot),
    .active         (active),
    .misalign_fault (misalign_fault)
  );

  typedef struct {
    logic        rst;
    logic        ce;
    logic        stl;
    logic        rv;
    logic [31:0] tgt;
    logic [31:0] exp_pc;
    logic        exp_ds;
    logic        exp_act;
    logic        exp_flt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic ce, input logic stl, input logic rv,
                              input logic [31:0] tgt, input logic [31:0] pc, input logic ds,
                              input logic act, input logic flt);
    vec_t v;
    v.rst = rst; v.ce = ce; v.stl = stl; v.rv = rv; v.tgt = tgt;
    v.exp_pc = pc; v.exp_ds = ds; v.exp_act = act; v.exp_flt = flt;
    return v;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act_v, exp_v);
    end
  endtask

  task automatic apply_check(input int idx, input vec_t v);
    logic [31:0] exp_p8;
    reset = v.rst; clk_enable = v.ce; stall = v.stl;
    redirect_valid = v.rv; redirect_target = v.tgt;
    @(posedge clk);
    #1;
    exp_p8 = v.exp_pc + 32'd8;
    chk32($sformatf("row%0d instr_address", idx), instr_address, v.exp_pc);
    chk32($sformatf("row%0d pc_plus8", idx), pc_plus8, exp_p8);
    chk32($sformatf("row%0d in_delay_slot", idx), {31'b0, in_delay_slot}, {31'b0, v.exp_ds});
    chk32($sformatf("row%0d active", idx), {31'b0, active}, {31'b0, v.exp_act});
    chk32($sformatf("row%0d misalign_fault", idx), {31'b0, misalign_fault}, {31'b0, v.exp_flt});
  endtask

  initial begin
    // reset held 2 cycles (second with clk_enable=0), then 3 advances
    vecs.push_back(mk(1, 1, 0, 0, 32'h0, 32'hBFC00000, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0, 32'hBFC00000, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0, 32'hBFC00004, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0, 32'hBFC00008, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0, 32'hBFC0000C, 0, 1, 0));
    // redirect at BFC00004 to B000FFFC
    vecs.push_back(mk(1, 1, 0, 0, 32'h0, 32'hBFC00000, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0, 32'hBFC00004, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 32'hB000FFFC, 32'hBFC00008, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0, 32'hB000FFFC, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0, 32'hB0010000, 0, 1, 0));
    // stalls and clock-enable gaps stretch the delay slot; redirect in DELAY ignored
    vecs.push_back(mk(0, 1, 0, 1, 32'h00001000, 32'hB0010004, 1, 1, 0));
    vecs.push_back(mk(0, 1, 1, 1, 32'h00001000, 32'hB0010004, 1, 1, 0));
    vecs.push_back(mk(0, 1, 1, 1, 32'h00001000, 32'hB0010004, 1, 1, 0));
    vecs.push_back(mk(0, 1, 1, 1, 32'h00001000, 32'hB0010004, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0, 32'hB0010004, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h00000100, 32'hB0010004, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 32'h00000100, 32'h00001000, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0, 32'h00001004, 0, 1, 0));
    // reset while in DELAY with clk_enable=0 drops the pending target
    vecs.push_back(mk(0, 1, 0, 1, 32'h00002000, 32'h00001008, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0, 32'hBFC00000, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0, 32'hBFC00004, 0, 1, 0));
    // jump to 0 halts after the delay slot; later edges and redirects have no effect
    vecs.push_back(mk(0, 1, 0, 1, 32'h0, 32'hBFC00008, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0, 32'h00000000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 32'h00000500, 32'h00000000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0, 32'h00000000, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0, 32'hBFC00000, 0, 1, 0));
    // pc+4 wrap from FFFFFFFC to 0 halts
    vecs.push_back(mk(0, 1, 0, 1, 32'hFFFFFFF8, 32'hBFC00004, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0, 32'hFFFFFFF8, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0, 32'hFFFFFFFC, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0, 32'h00000000, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0, 32'hBFC00000, 0, 1, 0));
    // misaligned target: fault + halt at delay slot when checked, else taken as-is
    vecs.push_back(mk(0, 1, 0, 1, 32'hB0000002, 32'hBFC00004, 1, 1, ALIGN));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0, ALIGN ? 32'hBFC00004 : 32'hB0000002, 0, !ALIGN, ALIGN));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0, ALIGN ? 32'hBFC00004 : 32'hB0000006, 0, !ALIGN, ALIGN));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0, 32'hBFC00000, 0, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply_check(i, vecs[i]);
    end

    // redirect presented during a RUN-state stall must not be sampled
    reset = 1'b0; clk_enable = 1'b1; stall = 1'b1;
    redirect_valid = 1'b1; redirect_target = 32'h00000300;
    repeat (2) @(posedge clk);
    #1;
    chk32("stall_run pc", instr_address, 32'hBFC00000);
    chk32("stall_run ds", {31'b0, in_delay_slot}, 32'h0);
    stall = 1'b0; redirect_valid = 1'b0;
    @(posedge clk);
    #1;
    chk32("after_stall pc", instr_address, 32'hBFC00004);
    chk32("after_stall ds", {31'b0, in_delay_slot}, 32'h0);
    // sampled on the advancing edge: one delay slot then the target
    redirect_valid = 1'b1;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    chk32("late_redir ds", {31'b0, in_delay_slot}, 32'h1);
    @(posedge clk);
    #1;
    chk32("late_redir pc", instr_address, 32'h00000300);
    chk32("late_redir p8", pc_plus8, 32'h00000308);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
